// File: rtl/key_event_decoder.sv
// PS/2 scancode-word decoder: turns completed words into {make, ext, code} events in a FIFO
// and tracks eight game keys. Define KEYDEC_EXT_EN to decode E0-prefixed (extended) keys.
module key_event_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] keyb_char,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [9:0]  evt_data,
  output logic [4:0]  evt_count,
  output logic [7:0]  key_held,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);

  logic [31:0]     r_cur, r_prev;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]      r_count;
  logic [7:0]      r_key_held;
  logic            r_overflow;

  logic       w_new, w_fmt_ok, w_code_ok, w_make, w_ext, w_push;
  logic       w_pop, w_full, w_accept, w_drop;
  logic [7:0] w_code, w_hit, w_key_held_d;

  // Both stages load the live word in reset so the word present at release is not an event.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cur  <= keyb_char;
      r_prev <= keyb_char;
    end else begin
      r_cur  <= keyb_char;
      r_prev <= r_cur;
    end
  end

  assign w_new  = (r_cur != r_prev);
  assign w_code = r_cur[7:0];

  always_comb begin
    w_fmt_ok = 1'b0;
    w_make   = 1'b0;
    w_ext    = 1'b0;
    unique case (r_cur[31:8])
      24'h000000: begin w_fmt_ok = 1'b1; w_make = 1'b1; end
      24'h0000F0: begin w_fmt_ok = 1'b1; end
`ifdef KEYDEC_EXT_EN
      24'h0000E0: begin w_fmt_ok = 1'b1; w_make = 1'b1; w_ext = 1'b1; end
      24'h00E0F0: begin w_fmt_ok = 1'b1; w_ext = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign w_code_ok = (w_code != 8'h00) && (w_code != 8'hE0) && (w_code != 8'hF0);
  assign w_push    = w_new && w_fmt_ok && w_code_ok;

  // Game-key match; extended keys only ever match when w_ext can be set.
  assign w_hit[0] = w_ext  && (w_code == 8'h75);
  assign w_hit[1] = w_ext  && (w_code == 8'h72);
  assign w_hit[2] = w_ext  && (w_code == 8'h6B);
  assign w_hit[3] = w_ext  && (w_code == 8'h74);
  assign w_hit[4] = !w_ext && (w_code == 8'h29);
  assign w_hit[5] = !w_ext && (w_code == 8'h5A);
  assign w_hit[6] = !w_ext && (w_code == 8'h1D);
  assign w_hit[7] = !w_ext && (w_code == 8'h1B);

  always_comb begin
    w_key_held_d = r_key_held;
    if (w_push) begin
      for (int i = 0; i < 8; i++) begin
        if (w_hit[i]) w_key_held_d[i] = w_make;
      end
    end
  end

  assign w_full   = (r_count == DepthCnt);
  assign w_pop    = (r_count != 5'd0) && evt_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_wr_ptr] <= {w_make, w_ext, w_code};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_key_held <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_key_held <= w_key_held_d;
      if (w_accept) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_accept && !w_pop)      r_count <= r_count + 5'd1;
      else if (!w_accept && w_pop) r_count <= r_count - 5'd1;
      // A fresh drop beats a simultaneous clear.
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign evt_valid = (r_count != 5'd0);
  assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : 10'h000;
  assign evt_count = r_count;
  assign key_held  = r_key_held;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed self-checking bench for key_event_decoder (FIFO_DEPTH = 4); expectations follow
// KEYDEC_EXT_EN when it is defined for the build.
module tb_key_event_decoder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] keyb_char;
  logic        evt_valid;
  logic        evt_ready;
  logic [9:0]  evt_data;
  logic [4:0]  evt_count;
  logic [7:0]  key_held;
  logic        overflow;
  logic        overflow_clr;

  int n_checks = 0;
  int n_errors = 0;

  key_event_decoder #(.FIFO_DEPTH(4)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .keyb_char   (keyb_char),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_count   (evt_count),
    .key_held    (key_held),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] word);
    keyb_char = word;
    step();
    step();
  endtask

  task automatic pop();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [9:0] exp);
    chk(tag, 32'(evt_data), 32'(exp));
    pop();
  endtask

  task automatic fill4();
    put(32'h0000001C);
    put(32'h00000032);
    put(32'h00000021);
    put(32'h00000023);
  endtask

  initial begin
    reset_n = 1'b0; keyb_char = 32'h0; evt_ready = 1'b0; overflow_clr = 1'b0;
    step(); step();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_data",  32'(evt_data),  0);
    chk("rst_count", 32'(evt_count), 0);
    chk("rst_held",  32'(key_held),  0);
    chk("rst_ovf",   32'(overflow),  0);
    reset_n = 1'b1;
    step();

    // Space make: event appears two edges after the change.
    keyb_char = 32'h00000029;
    step();
    chk("lat_valid_early", 32'(evt_valid), 0);
    step();
    chk("space_valid", 32'(evt_valid), 1);
    chk("space_data",  32'(evt_data),  32'h229);
    chk("space_held",  32'(key_held),  32'h10);
    chk("space_count", 32'(evt_count), 1);
    pop();
    chk("pop_count", 32'(evt_count), 0);
    chk("pop_data",  32'(evt_data),  0);

    put(32'h00001234);
    chk("bad_fmt_count", 32'(evt_count), 0);
    put(32'h000000F0);
    chk("bad_code_count", 32'(evt_count), 0);
    chk("bad_code_held",  32'(key_held),  32'h10);

    put(32'h0000E075);
`ifdef KEYDEC_EXT_EN
    chk("ext_make_data", 32'(evt_data), 32'h375);
    chk("ext_make_held", 32'(key_held), 32'h11);
    put(32'h00E0F075);
    chk("ext_brk_count", 32'(evt_count), 2);
    chk("ext_brk_held",  32'(key_held),  32'h10);
    pop_chk("ext_head0", 10'h375);
    pop_chk("ext_head1", 10'h175);
`else
    chk("ext_off_count", 32'(evt_count), 0);
    chk("ext_off_held",  32'(key_held),  32'h10);
    put(32'h00E0F075);
    chk("ext_off_count2", 32'(evt_count), 0);
    pop();
`endif
    chk("empty_ready_count", 32'(evt_count), 0);
    chk("empty_ready_valid", 32'(evt_valid), 0);

    // Enter make/break, then a repeated space make keeps bit 4 set.
    put(32'h0000005A);
    chk("enter_held", 32'(key_held), 32'h30);
    put(32'h0000F05A);
    chk("enter_brk_held", 32'(key_held), 32'h10);
    put(32'h00000029);
    chk("rep_make_held", 32'(key_held),  32'h10);
    chk("three_count",   32'(evt_count), 3);
    pop_chk("q0", 10'h25A);
    pop_chk("q1", 10'h05A);
    pop_chk("q2", 10'h229);
    chk("q_empty", 32'(evt_count), 0);

    // Five pushes into depth 4: fifth (W make) dropped but still sets key_held[6].
    fill4();
    put(32'h0000001D);
    chk("ovf_count", 32'(evt_count), 4);
    chk("ovf_flag",  32'(overflow),  1);
    chk("ovf_held",  32'(key_held),  32'h50);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    pop_chk("ovf_q0", 10'h21C);
    pop_chk("ovf_q1", 10'h232);
    pop_chk("ovf_q2", 10'h221);
    pop_chk("ovf_q3", 10'h223);
    chk("ovf_fifth_absent", 32'(evt_count), 0);

    // Full FIFO with simultaneous push and pop.
    fill4();
    keyb_char = 32'h0000001B;
    step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("pp_count", 32'(evt_count), 4);
    chk("pp_ovf",   32'(overflow),  0);
    chk("pp_held",  32'(key_held),  32'hD0);
    pop_chk("pp_q0", 10'h232);
    pop_chk("pp_q1", 10'h221);
    pop_chk("pp_q2", 10'h223);
    pop_chk("pp_q3", 10'h21B);

    // Drop and clear on the same edge: set wins.
    fill4();
    keyb_char = 32'h00000024;
    step();
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("setwin_ovf",   32'(overflow),  1);
    chk("setwin_count", 32'(evt_count), 4);

    // Word present at reset release produces nothing.
    reset_n = 1'b0;
    keyb_char = 32'h0000F05A;
    step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    chk("rel_count", 32'(evt_count), 0);
    chk("rel_held",  32'(key_held),  0);
    chk("rel_ovf",   32'(overflow),  0);
    put(32'h0000005A);
    chk("rel_evt_data", 32'(evt_data), 32'h25A);
    chk("rel_evt_held", 32'(key_held), 32'h20);

    // Reset with a word in flight clears everything and discards it.
    keyb_char = 32'h00000029;
    step();
    reset_n = 1'b0;
    step();
    chk("mid_valid", 32'(evt_valid), 0);
    chk("mid_data",  32'(evt_data),  0);
    chk("mid_count", 32'(evt_count), 0);
    chk("mid_held",  32'(key_held),  0);
    chk("mid_ovf",   32'(overflow),  0);
    reset_n = 1'b1;
    step(); step(); step();
    chk("mid_after_count", 32'(evt_count), 0);
    chk("mid_after_held",  32'(key_held),  0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
